// File: rtl/decode_ctrl_stage_if.sv
// Fetch-side and execute-side handshake bundle for decode_ctrl_stage.
// slave = decode stage view, master = driver/observer view.
interface decode_ctrl_stage_if #(
    parameter int XLEN = 32
);
    logic            if_valid;
    logic [31:0]     if_instr;
    logic [XLEN-1:0] if_pc;
    logic            id_ready;
    logic            flush;
    logic            ex_ready;
    logic            ex_valid;
    logic [XLEN-1:0] ex_pc;
    logic [4:0]      ex_rs1;
    logic [4:0]      ex_rs2;
    logic [4:0]      ex_rd;
    logic [2:0]      ex_funct3;
    logic            ex_regWrite;
    logic            ex_memToReg;
    logic            ex_store;
    logic            ex_branch;
    logic            ex_jump;
    logic            ex_opB;
    logic            ex_illegal;
    logic [1:0]      ex_opA;
    logic [2:0]      ex_immSel;
    logic [1:0]      ex_nextPc;
    logic [3:0]      ex_aluSel;
    logic [XLEN-1:0] ex_imm;

    modport slave (
        input  if_valid, if_instr, if_pc, flush, ex_ready,
        output id_ready, ex_valid, ex_pc, ex_rs1, ex_rs2, ex_rd,
        output ex_funct3, ex_regWrite, ex_memToReg, ex_store,
        output ex_branch, ex_jump, ex_opB, ex_illegal, ex_opA,
        output ex_immSel, ex_nextPc, ex_aluSel, ex_imm
    );

    modport master (
        output if_valid, if_instr, if_pc, flush, ex_ready,
        input  id_ready, ex_valid, ex_pc, ex_rs1, ex_rs2, ex_rd,
        input  ex_funct3, ex_regWrite, ex_memToReg, ex_store,
        input  ex_branch, ex_jump, ex_opB, ex_illegal, ex_opA,
        input  ex_immSel, ex_nextPc, ex_aluSel, ex_imm
    );
endinterface

// File: rtl/decode_ctrl_stage.sv
// RV32I/RV64I decode stage: opcode classify, control + immediate, ID/EX reg.
// Ports: clk, rst_n, bus (slave: if_* in, id_ready out, ex_* out), stall_count.
module decode_ctrl_stage #(
    parameter int XLEN        = 32,
    parameter int LOAD_USE_EN = 1,
    parameter int CNT_W       = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    decode_ctrl_stage_if.slave   bus,
    output logic [CNT_W-1:0]     stall_count
);

    typedef struct packed {
        logic            valid;
        logic [XLEN-1:0] pc;
        logic [4:0]      rs1;
        logic [4:0]      rs2;
        logic [4:0]      rd;
        logic [2:0]      funct3;
        logic            regWrite;
        logic            memToReg;
        logic            store;
        logic            branch;
        logic            jump;
        logic            opB;
        logic            illegal;
        logic [1:0]      opA;
        logic [2:0]      immSel;
        logic [1:0]      nextPc;
        logic [3:0]      aluSel;
        logic [XLEN-1:0] imm;
    } bundle_t;

    localparam logic [6:0] OP_R   = 7'b0110011;
    localparam logic [6:0] OP_I   = 7'b0010011;
    localparam logic [6:0] OP_L   = 7'b0000011;
    localparam logic [6:0] OP_S   = 7'b0100011;
    localparam logic [6:0] OP_B   = 7'b1100011;
    localparam logic [6:0] OP_J   = 7'b1101111;
    localparam logic [6:0] OP_JR  = 7'b1100111;
    localparam logic [6:0] OP_LUI = 7'b0110111;
    localparam logic [6:0] OP_AUI = 7'b0010111;

    logic [31:0] ins;
    logic [6:0]  opc;
    logic [2:0]  f3;
    logic        is_r, is_i, is_l, is_s, is_b;
    logic        is_j, is_jr, is_lui, is_aui;
    logic        uses_rs1, uses_rs2;
    logic [31:0] imm32;
    bundle_t     d;
    bundle_t     q;
    logic        adv;
    logic        hazard;

    assign ins    = bus.if_instr;
    assign opc    = ins[6:0];
    assign f3     = ins[14:12];
    assign is_r   = (opc == OP_R);
    assign is_i   = (opc == OP_I);
    assign is_l   = (opc == OP_L);
    assign is_s   = (opc == OP_S);
    assign is_b   = (opc == OP_B);
    assign is_j   = (opc == OP_J);
    assign is_jr  = (opc == OP_JR);
    assign is_lui = (opc == OP_LUI);
    assign is_aui = (opc == OP_AUI);

    assign uses_rs1 = is_r | is_i | is_l | is_s | is_b | is_jr;
    assign uses_rs2 = is_r | is_s | is_b;

    always_comb begin
        d        = '0;
        d.valid  = 1'b1;
        d.pc     = bus.if_pc;
        d.rs1    = ins[19:15];
        d.rs2    = ins[24:20];
        d.rd     = ins[11:7];
        d.funct3 = f3;
        unique case (1'b1)
            is_r: begin
                d.regWrite = 1'b1;
                d.aluSel   = {ins[30], f3};
            end
            is_i: begin
                d.regWrite = 1'b1;
                d.opB      = 1'b1;
                d.aluSel   = {ins[30] & (f3 == 3'b101), f3};
            end
            is_l: begin
                d.regWrite = 1'b1;
                d.memToReg = 1'b1;
                d.opB      = 1'b1;
            end
            is_s: begin
                d.store  = 1'b1;
                d.opB    = 1'b1;
                d.immSel = 3'b001;
            end
            is_b: begin
                d.branch = 1'b1;
                d.opA    = 2'b01;
                d.immSel = 3'b010;
                d.nextPc = 2'b01;
            end
            is_j: begin
                d.regWrite = 1'b1;
                d.jump     = 1'b1;
                d.opB      = 1'b1;
                d.opA      = 2'b01;
                d.immSel   = 3'b100;
                d.nextPc   = 2'b10;
            end
            is_jr: begin
                d.regWrite = 1'b1;
                d.jump     = 1'b1;
                d.opB      = 1'b1;
                d.nextPc   = 2'b11;
            end
            is_lui: begin
                d.regWrite = 1'b1;
                d.opB      = 1'b1;
                d.opA      = 2'b10;
                d.immSel   = 3'b011;
            end
            is_aui: begin
                d.regWrite = 1'b1;
                d.opB      = 1'b1;
                d.opA      = 2'b01;
                d.immSel   = 3'b011;
            end
            default: d.illegal = 1'b1;
        endcase

        imm32 = '0;
        unique case (d.immSel)
            3'b001:  imm32 = {{20{ins[31]}}, ins[31:25], ins[11:7]};
            3'b010:  imm32 = {{19{ins[31]}}, ins[31], ins[7],
                              ins[30:25], ins[11:8], 1'b0};
            3'b011:  imm32 = {ins[31:12], 12'b0};
            3'b100:  imm32 = {{11{ins[31]}}, ins[31], ins[19:12],
                              ins[20], ins[30:21], 1'b0};
            default: imm32 = {{20{ins[31]}}, ins[31:20]};
        endcase
        // Every format is already sign-extended to 32 bits; widen by sign.
        if (!d.illegal)
            d.imm = XLEN'($signed(imm32));
    end

    assign adv = !q.valid | bus.ex_ready;

    assign hazard = (LOAD_USE_EN != 0) & q.valid & q.memToReg &
                    (q.rd != 5'd0) &
                    (((q.rd == ins[19:15]) & uses_rs1) |
                     ((q.rd == ins[24:20]) & uses_rs2));

    assign bus.id_ready = adv & !hazard;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q           <= '0;
            stall_count <= '0;
        end else if (bus.flush) begin
            q <= '0;
        end else if (adv) begin
            if (bus.if_valid & !hazard)
                q <= d;
            else
                q <= '0;
            if (bus.if_valid & hazard & !(&stall_count))
                stall_count <= stall_count + CNT_W'(1);
        end
    end

    assign bus.ex_valid    = q.valid;
    assign bus.ex_pc       = q.pc;
    assign bus.ex_rs1      = q.rs1;
    assign bus.ex_rs2      = q.rs2;
    assign bus.ex_rd       = q.rd;
    assign bus.ex_funct3   = q.funct3;
    assign bus.ex_regWrite = q.regWrite;
    assign bus.ex_memToReg = q.memToReg;
    assign bus.ex_store    = q.store;
    assign bus.ex_branch   = q.branch;
    assign bus.ex_jump     = q.jump;
    assign bus.ex_opB      = q.opB;
    assign bus.ex_illegal  = q.illegal;
    assign bus.ex_opA      = q.opA;
    assign bus.ex_immSel   = q.immSel;
    assign bus.ex_nextPc   = q.nextPc;
    assign bus.ex_aluSel   = q.aluSel;
    assign bus.ex_imm      = q.imm;

endmodule
